// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : Shared types and helpers for the bit-serial subtractor slice.
//            - state_t     : FSM encoding (IDLE, SHIFT, DONE)
//            - cnt_width() : bit-counter width, clog2(WIDTH), minimum 1
//            - c_MODE_*    : operation-select encodings for the optional
//                            add mode (SERIAL_ADD_EN builds only)
// Revision : 1.0  initial release
// ============================================================================
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic c_MODE_ADD = 1'b1;
  localparam logic c_MODE_SUB = 1'b0;

  // clog2 evaluated at elaboration; a 1-bit counter is the floor so that
  // WIDTH = 2 still yields a legal vector.
  function automatic int cnt_width(input int width);
    int w;
    w = 1;
    while ((1 << w) < width) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor_bit.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor_bit
// Purpose  : Combinational 1-bit full subtractor, computes a - b - borrow_in.
// Ports    : a, b, borrow_in  (in)  operand bits and incoming borrow
//            diff             (out) difference bit
//            borrow_out       (out) outgoing borrow
// Revision : 1.0  initial release
// ============================================================================
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  logic w_axb;

  assign w_axb      = a ^ b;
  assign diff       = w_axb ^ borrow_in;
  // Borrow when b exceeds a outright, or when they tie and a borrow ripples in.
  assign borrow_out = (~a & b) | (~w_axb & borrow_in);

endmodule : full_subtractor_bit
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial, LSB-first two's-complement subtractor, diff = a - b,
//            one bit per clock over WIDTH cycles with a start/busy/done
//            handshake.
// Ports    : clk        (in)  rising-edge clock
//            rst_n      (in)  asynchronous active-low reset
//            start      (in)  request, sampled in IDLE and DONE
//            a, b       (in)  operands, captured on accepted start
//            mode       (in)  1 = add, 0 = subtract (SERIAL_ADD_EN only)
//            busy       (out) serial operation in progress
//            done       (out) one-cycle result-valid pulse
//            diff       (out) result, held until the next result
//            borrow_out (out) final borrow (final carry in add mode)
//            overflow   (out) signed overflow of the operation
// Config   : `define SERIAL_ADD_EN adds the mode port and add operation.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int c_CNT_W = cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_br;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_a_sign;
  logic               r_b_sign;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_ovf;

  logic             w_load;
  logic             w_last;
  logic             w_d;
  logic             w_sub_br;
  logic             w_br_next;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_next;

  // --------------------------------------------------------------------------
  // Serial cell
  // --------------------------------------------------------------------------
  full_subtractor_bit u_fsb (
    .a          (r_a[0]),
    .b          (r_b[0]),
    .borrow_in  (r_br),
    .diff       (w_d),
    .borrow_out (w_sub_br)
  );

`ifdef SERIAL_ADD_EN
  logic r_mode;
  logic w_is_add;
  logic w_carry;

  assign w_is_add  = (r_mode == c_MODE_ADD);
  // Sum and difference bits share the same three-input XOR, so only the
  // carry/borrow chain differs between modes; r_br holds either.
  assign w_carry   = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_br);
  assign w_br_next = w_is_add ? w_carry : w_sub_br;
  assign w_ovf     = w_is_add ? ((r_a_sign == r_b_sign) && (w_d != r_a_sign))
                              : ((r_a_sign != r_b_sign) && (w_d != r_a_sign));
`else
  assign w_br_next = w_sub_br;
  assign w_ovf     = (r_a_sign != r_b_sign) && (w_d != r_a_sign);
`endif

  // The bit computed this cycle lands in the MSB; after WIDTH shifts the
  // LSB-first stream is right-aligned.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == c_LAST);
  assign w_load     = start && ((r_state == IDLE) || (r_state == DONE));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? SHIFT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      // done trails the DONE state by one edge so it lands WIDTH+1 edges
      // after the accepting edge; the result registers are already stable.
      r_done <= (r_state == DONE);

      if (w_load) begin
        r_a      <= a;
        r_b      <= b;
        r_res    <= '0;
        r_br     <= 1'b0;
        r_cnt    <= '0;
        r_a_sign <= a[WIDTH-1];
        r_b_sign <= b[WIDTH-1];
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= w_res_next;
        r_br  <= w_br_next;
        if (w_last) begin
          r_diff   <= w_res_next;
          r_borrow <= w_br_next;
          r_ovf    <= w_ovf;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end
  end

`ifdef SERIAL_ADD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= c_MODE_SUB;
    end else if (w_load) begin
      r_mode <= mode;
    end
  end
`endif

  assign busy       = (r_state == SHIFT);
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed self-checking bench for serial_subtractor (WIDTH = 8).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int c_W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [c_W-1:0] a;
  logic [c_W-1:0] b;
`ifdef SERIAL_ADD_EN
  logic           mode;
`endif
  logic           busy;
  logic           done;
  logic [c_W-1:0] diff;
  logic           borrow_out;
  logic           overflow;

  int n_vec;
  int n_err;

  serial_subtractor #(.WIDTH(c_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef SERIAL_ADD_EN
    .mode       (mode),
`endif
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits up to 'limit' edges for done; returns the edge index it was seen on
  // (0 if never).
  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    wait_done(20, lat);
    chk({tag, ".lat"}, lat, 9);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".brw"}, borrow_out, eb);
    chk({tag, ".ovf"}, overflow, eo);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int ndone;
    logic [7:0] seen;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADD_EN
    mode = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.diff", diff, 0);
    chk("rst.brw", borrow_out, 0);
    chk("rst.ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    do_op("t2a", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    do_op("t2b", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    do_op("t3a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    do_op("t3b", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Start re-pulsed during SHIFT must be ignored.
    @(negedge clk);
    a = 8'h20; b = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    seen  = '0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        seen = diff;
      end
    end
    chk("t4.ndone", ndone, 1);
    chk("t4.diff", seen, 8'h19);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.busy", busy, 0);
    chk("t5.done", done, 0);
    chk("t5.diff", diff, 0);
    chk("t5.ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(12, lat);
    chk("t5.nodone", lat, 0);
    do_op("t5r", 8'h40, 8'h41, 8'hFF, 1'b1, 1'b0);

    // Back-to-back: start held through DONE captures the second pair.
    @(negedge clk);
    a = 8'h09; b = 8'h0A; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h10; b = 8'h01;
    wait_done(20, lat);
    chk("t6.lat1", lat, 9);
    chk("t6.diff1", diff, 8'hFF);
    chk("t6.brw1", borrow_out, 1);
    chk("t6.busy", busy, 1);
    start = 1'b0;
    wait_done(20, lat);
    chk("t6.lat2", lat, 9);
    chk("t6.diff2", diff, 8'h0F);
    chk("t6.brw2", borrow_out, 0);
    chk("t6.ovf2", overflow, 0);

`ifdef SERIAL_ADD_EN
    mode = 1'b1;
    do_op("add1", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    do_op("add2", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    mode = 1'b0;
    do_op("sub", 8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first two's-complement subtractor computing diff = a - b over WIDTH clock cycles.
- One 1-bit full-subtractor cell plus a registered borrow flip-flop. It is the subtracting counterpart of the team's 1-bit full adder.
- Sits in the lab datapath as a small-area ALU slice, driven by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while the serial operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result; held stable from done until the next accepted start.
- borrow_out  output  1  final borrow; 1 means a < b (unsigned).
- overflow  output  1  signed overflow of a - b.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, borrow_out = 0, overflow = 0.
  - Internal shift registers, borrow flip-flop and bit counter all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 loads a and b into shift registers A and B.
  - Clears the borrow flip-flop and the counter, captures sign bits a[WIDTH-1] and b[WIDTH-1], then goes to SHIFT.
  - busy rises on the cycle after start.
- SHIFT (one bit per cycle; a0 = A[0], b0 = B[0], br = borrow flip-flop):
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the result register (right shift); A and B shift right; the counter increments.
  - When the counter reaches WIDTH-1 this cycle: go to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy = 0.
  - diff = result register; borrow_out = final br.
  - overflow = (a_sign != b_sign) && (diff[WIDTH-1] != a_sign).
  - Next state is IDLE, or SHIFT directly if start = 1 in DONE (back-to-back operation, new operands captured).
- Latency: start accepted at edge 0 gives done high after edge WIDTH+1; throughput is one operation per WIDTH+1 cycles.
- start while busy (SHIFT) is ignored, and operand inputs are don't-care during SHIFT.
- diff, borrow_out and overflow change only on the DONE-entry edge (and on reset); they are not cleared by a new start.
- Reset mid-operation aborts immediately to the reset values above, with no partial result and no done pulse.
- Counter width is clog2(WIDTH); there is no wrap-around beyond WIDTH-1.

Optional Feature:
- Macro SERIAL_ADD_EN.
- Defined:
  - Adds input port mode (1 bit, captured with operands): 1 = add, 0 = subtract.
  - Add mode uses carry logic: carry_next = (a0 & b0) | ((a0 ^ b0) & c). borrow_out then reports the final carry.
  - Add-mode overflow = (a_sign == b_sign) && (diff[WIDTH-1] != a_sign).
- Undefined: port absent, subtract only.

Decomposition:
- Package serial_subtractor_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - function for counter width = clog2(WIDTH).
  - localparam for the mode encodings (ADD = 1, SUB = 0).
- Sub-module full_subtractor_bit: combinational, inputs a, b, borrow_in; outputs diff, borrow_out. Instantiated once in the serial datapath.

Test Plan (WIDTH = 8):
1. a=0x05, b=0x03, start pulse -> done 9 cycles after the start edge; diff=0x02, borrow_out=0, overflow=0.
2. a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0; a=0x00, b=0x00 -> diff=0x00, borrow_out=0.
3. a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1; a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
4. Start accepted, then start re-pulsed with new operands at cycle 3 -> ignored; result equals the first operands, and only one done pulse.
5. rst_n driven low at cycle 4 of an operation -> busy=0, done=0, diff=0 asynchronously; a fresh start after release gives the correct result.
6. start held high through DONE with a=0x10, b=0x01 -> back-to-back second result diff=0x0F, with no IDLE cycle. With SERIAL_ADD_EN: mode=1, a=0xFF, b=0x01 -> diff=0x00, borrow_out(carry)=1, overflow=0.
